// File: rtl/camera_init_sequencer_if.sv
// Write channel between the init sequencer and the SCCB master.
// The master side holds addr/data stable while wr_req is high; the slave answers with 1-clk ack/nack pulses.
interface camera_init_sequencer_if #(
  parameter int RA_W = 8,
  parameter int RD_W = 8
);
  logic            wr_req;
  logic [RA_W-1:0] wr_addr;
  logic [RD_W-1:0] wr_data;
  logic            wr_ack;
  logic            wr_nack;

  modport master (output wr_req, wr_addr, wr_data, input  wr_ack, wr_nack);
  modport slave  (input  wr_req, wr_addr, wr_data, output wr_ack, wr_nack);
endinterface

// File: rtl/camera_init_sequencer.sv
// Table-driven sensor init engine: walks a sync-ROM register table, issues SCCB writes,
// handles inline delay entries, soft-reset settle time, NACK retry and restart.
module camera_init_sequencer #(
  parameter int                 RA_W       = 8,
  parameter int                 RD_W       = 8,
  parameter int                 TBL_AW     = 8,
  parameter int                 TBL_LEN    = 68,
  parameter logic [RA_W-1:0]    DELAY_ADDR = '1,
  parameter int                 DELAY_UNIT = 50000,
  parameter logic [RA_W-1:0]    RST_REG    = RA_W'(8'h12),
  parameter int                 RST_WAIT   = 50000,
  parameter int                 PWRUP_WAIT = 100000,
  parameter int                 MAX_RETRY  = 3,
  parameter int                 AUTO_START = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  output logic [TBL_AW-1:0]      tbl_addr,
  input  logic [RA_W+RD_W-1:0]   tbl_q,
  camera_init_sequencer_if.master wr,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic [TBL_AW-1:0]      fail_idx
);

  // Timer covers the longest of power-up, reset settle and a max-data delay entry.
  localparam logic [63:0] DLY_MAX = ((64'd1 << RD_W) - 64'd1) * 64'(DELAY_UNIT);
  localparam logic [63:0] T_A     = (64'(PWRUP_WAIT) > 64'(RST_WAIT)) ? 64'(PWRUP_WAIT) : 64'(RST_WAIT);
  localparam logic [63:0] T_MAX   = (T_A > DLY_MAX) ? T_A : DLY_MAX;
  localparam int          TW      = (T_MAX < 64'd2) ? 1 : $clog2(T_MAX + 64'd1);
  localparam int          RW      = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [TBL_AW-1:0] LAST = TBL_AW'(TBL_LEN - 1);
  localparam logic [TW-1:0] PW_LOAD  = (PWRUP_WAIT > 0) ? TW'(PWRUP_WAIT - 1) : '0;

  typedef enum logic [2:0] {IDLE, PWRUP, FETCH, LATCH, WRITE, DLY, DONE, FAIL} state_t;

  state_t            state, state_n;
  logic [TBL_AW-1:0] idx, idx_n, fidx, fidx_n;
  logic [RW-1:0]     retry, retry_n;
  logic [TW-1:0]     timer, timer_n;
  logic              wreq, wreq_n, first, advance;
  logic [RA_W-1:0]   waddr, waddr_n;
  logic [RD_W-1:0]   wdata, wdata_n;

  logic [RA_W-1:0]   q_addr;
  logic [RD_W-1:0]   q_data;
  logic              is_rst;

  assign q_addr = tbl_q[RA_W+RD_W-1:RD_W];
  assign q_data = tbl_q[RD_W-1:0];
  assign is_rst = (waddr == RST_REG) && wdata[7];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
      retry <= '0;
      timer <= '0;
      wreq  <= 1'b0;
      waddr <= '0;
      wdata <= '0;
      fidx  <= '0;
      first <= 1'b1;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      retry <= retry_n;
      timer <= timer_n;
      wreq  <= wreq_n;
      waddr <= waddr_n;
      wdata <= wdata_n;
      fidx  <= fidx_n;
      first <= 1'b0;
    end
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    retry_n = retry;
    timer_n = timer;
    wreq_n  = wreq;
    waddr_n = waddr;
    wdata_n = wdata;
    fidx_n  = fidx;
    advance = 1'b0;
    case (state)
      IDLE, DONE, FAIL: begin
        if (start || (state == IDLE && AUTO_START != 0 && first)) begin
          state_n = PWRUP;
          timer_n = PW_LOAD;
          idx_n   = '0;
          retry_n = '0;
        end
      end
      PWRUP: begin
        if (timer == '0) state_n = FETCH;
        else             timer_n = timer - 1'b1;
      end
      FETCH: state_n = LATCH;
      LATCH: begin
        if (q_addr == DELAY_ADDR) begin
          timer_n = TW'(64'(q_data) * 64'(DELAY_UNIT));
          state_n = DLY;
        end else begin
          waddr_n = q_addr;
          wdata_n = q_data;
          wreq_n  = 1'b1;
          state_n = WRITE;
        end
      end
      WRITE: begin
        // wreq low inside WRITE is the one-cycle gap before a retry re-issue
        if (!wreq) begin
          wreq_n = 1'b1;
        end else if (wr.wr_nack) begin
          wreq_n = 1'b0;
          if (int'(retry) < MAX_RETRY) begin
            retry_n = retry + 1'b1;
          end else begin
            fidx_n  = idx;
            state_n = FAIL;
          end
        end else if (wr.wr_ack) begin
          wreq_n = 1'b0;
          if (is_rst) begin
            timer_n = TW'(RST_WAIT);
            state_n = DLY;
          end else begin
            advance = 1'b1;
          end
        end
      end
      DLY: begin
        if (timer == '0) advance = 1'b1;
        else             timer_n = timer - 1'b1;
      end
      default: state_n = IDLE;
    endcase
    if (advance) begin
      retry_n = '0;
      if (idx == LAST) begin
        state_n = DONE;
      end else begin
        idx_n   = idx + 1'b1;
        state_n = FETCH;
      end
    end
  end

  assign tbl_addr   = idx;
  assign fail_idx   = fidx;
  assign wr.wr_req  = wreq;
  assign wr.wr_addr = waddr;
  assign wr.wr_data = wdata;
  assign busy       = (state == PWRUP) || (state == FETCH) || (state == LATCH) ||
                      (state == WRITE) || (state == DLY);
  assign done       = (state == DONE);
  assign error      = (state == FAIL);

endmodule

// File: tb/tb_camera_init_sequencer.sv
// Bench for camera_init_sequencer: ROM model, ack/nack responder, write scoreboard,
// table of runs with nack plans, plus reset-mid-write and start-while-busy sequences.
module tb_camera_init_sequencer;
  localparam int MR = 2;

  logic        clk = 1'b0;
  logic        rst_n, start;
  logic [3:0]  tbl_addr, fail_idx;
  logic [15:0] tbl_q;
  logic        busy, done, error;

  camera_init_sequencer_if #(.RA_W(8), .RD_W(8)) bus();

  camera_init_sequencer #(
    .RA_W(8), .RD_W(8), .TBL_AW(4), .TBL_LEN(8), .DELAY_ADDR(8'hFF), .DELAY_UNIT(8),
    .RST_REG(8'h12), .RST_WAIT(10), .PWRUP_WAIT(20), .MAX_RETRY(MR), .AUTO_START(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .tbl_addr(tbl_addr), .tbl_q(tbl_q),
    .wr(bus), .busy(busy), .done(done), .error(error), .fail_idx(fail_idx)
  );

  always #5 clk = ~clk;

  logic [15:0] rom [16];
  always @(posedge clk) tbl_q <= rom[tbl_addr];

  int checks = 0, failures = 0, cyc = 0, pulses = 0;
  logic [15:0] exp_q[$];
  logic [7:0]  nack_addr = 8'h00;
  int          nack_left = 0;
  logic [7:0]  last_ack_addr = 8'h00;
  int          last_ack_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: expected write stream for one pass given a nack plan.
  function automatic void build_q(input logic [7:0] na, input int cnt);
    int  left;
    bit  failed;
    left   = cnt;
    failed = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 8 && !failed; i++) begin
      if (rom[i][15:8] == 8'hFF) continue;
      if (rom[i][15:8] != na) begin
        exp_q.push_back(rom[i]);
        continue;
      end
      for (int a = 0; a <= MR; a++) begin
        exp_q.push_back(rom[i]);
        if (left == 0) break;
        left--;
        if (a == MR) failed = 1'b1;
      end
    end
  endfunction

  // SCCB responder: answers each request 5 clks after it rises
  initial begin
    int wait_n;
    bit armed;
    armed = 1'b0;
    wait_n = 0;
    bus.wr_ack = 1'b0;
    bus.wr_nack = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.wr_ack && last_ack_addr == 8'h23) begin
        chk("done_one_clk_after_last_ack", {31'd0, done}, 32'd1);
        chk("busy_low_after_last_ack", {31'd0, busy}, 32'd0);
      end
      bus.wr_ack = 1'b0;
      bus.wr_nack = 1'b0;
      if (!rst_n) begin
        armed = 1'b0;
        last_ack_addr = 8'h00;
      end else if (armed) begin
        wait_n--;
        if (wait_n == 0) begin
          armed = 1'b0;
          if (bus.wr_addr == nack_addr && nack_left > 0) begin
            nack_left--;
            bus.wr_nack = 1'b1;
          end else begin
            bus.wr_ack = 1'b1;
            last_ack_addr = bus.wr_addr;
            last_ack_cyc = cyc;
          end
        end
      end else if (bus.wr_req) begin
        armed = 1'b1;
        wait_n = 5;
      end
    end
  end

  // Monitor: scoreboard pop on each wr_req rise, stability while held
  initial begin
    logic        prev;
    logic [15:0] cur;
    prev = 1'b0;
    cur = 16'h0;
    forever begin
      @(negedge clk);
      if (bus.wr_req && !prev) begin
        pulses++;
        cur = {bus.wr_addr, bus.wr_data};
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write actual=%0h expected=none t=%0t", cur, $time);
        end else begin
          chk("write_order", {16'd0, cur}, {16'd0, exp_q.pop_front()});
        end
        if (last_ack_addr == 8'h12)
          chk("rst_settle_gap_ge10", {31'd0, (cyc - last_ack_cyc) >= 10}, 32'd1);
        if (last_ack_addr == 8'h3d)
          chk("delay_gap_ge32", {31'd0, (cyc - last_ack_cyc) >= 32}, 32'd1);
      end else if (bus.wr_req && prev) begin
        chk("wr_stable", {16'd0, bus.wr_addr, bus.wr_data}, {16'd0, cur});
      end
      prev = bus.wr_req;
    end
  end

  typedef struct {
    logic [7:0] nack_addr;
    int         nack_cnt;
    bit         mid_start;
    logic       exp_done;
    logic       exp_error;
    logic [3:0] exp_fidx;
    int         exp_writes;
  } run_t;
  run_t runs[5];

  task automatic wait_end();
    int n;
    n = 0;
    while (!(done || error) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("end_timeout", {31'd0, n < 2000}, 32'd1);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_wr_req"}, {31'd0, bus.wr_req}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_error"}, {31'd0, error}, 32'd0);
    chk({tag, "_tbl_addr"}, {28'd0, tbl_addr}, 32'd0);
    chk({tag, "_fail_idx"}, {28'd0, fail_idx}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int p;
    int n;
    logic [3:0] ta;
    foreach (rom[i]) rom[i] = 16'h0000;
    rom[0] = 16'h1280; rom[1] = 16'h3d03; rom[2] = 16'hFF04; rom[3] = 16'h1502;
    rom[4] = 16'h2011; rom[5] = 16'h2122; rom[6] = 16'h2233; rom[7] = 16'h2344;
    //          nack   cnt  mid   done  err   fidx  writes
    runs[0] = '{8'h00, 0,  1'b0, 1'b1, 1'b0, 4'd0, 7};
    runs[1] = '{8'h15, 2,  1'b1, 1'b1, 1'b0, 4'd0, 9};
    runs[2] = '{8'h21, 99, 1'b0, 1'b0, 1'b1, 4'd5, 7};
    runs[3] = '{8'h12, 1,  1'b0, 1'b1, 1'b0, 4'd0, 8};
    runs[4] = '{8'h23, 3,  1'b0, 1'b0, 1'b1, 4'd7, 9};

    rst_n = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check_reset("reset");

    for (int r = 0; r < 5; r++) begin
      nack_addr = runs[r].nack_addr;
      nack_left = runs[r].nack_cnt;
      build_q(runs[r].nack_addr, runs[r].nack_cnt);
      pulses = 0;
      if (r == 0) begin
        rst_n = 1'b1;
      end else begin
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_clears_done", {31'd0, done}, 32'd0);
        chk("start_clears_error", {31'd0, error}, 32'd0);
        chk("start_sets_busy", {31'd0, busy}, 32'd1);
      end
      if (runs[r].mid_start) begin
        repeat (40) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_ignored_while_busy", {31'd0, busy}, 32'd1);
      end
      wait_end();
      @(negedge clk);
      chk("run_done", {31'd0, done}, {31'd0, runs[r].exp_done});
      chk("run_error", {31'd0, error}, {31'd0, runs[r].exp_error});
      chk("run_busy_low", {31'd0, busy}, 32'd0);
      chk("run_write_count", pulses, runs[r].exp_writes);
      chk("run_queue_drained", exp_q.size(), 32'd0);
      if (runs[r].exp_error) begin
        chk("fail_idx", {28'd0, fail_idx}, {28'd0, runs[r].exp_fidx});
        p = pulses;
        ta = tbl_addr;
        repeat (30) @(negedge clk);
        chk("no_write_after_fail", pulses, p);
        chk("no_fetch_after_fail", {28'd0, tbl_addr}, {28'd0, ta});
        chk("error_held", {31'd0, error}, 32'd1);
      end
    end

    // Async reset while a write is outstanding, then auto-start rerun
    nack_addr = 8'h00;
    nack_left = 0;
    build_q(8'h00, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!bus.wr_req && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("wr_req_seen_before_reset", {31'd0, bus.wr_req}, 32'd1);
    #2 rst_n = 1'b0;
    #1 check_reset("async_reset");
    build_q(8'h00, 0);
    repeat (2) @(negedge clk);
    pulses = 0;
    rst_n = 1'b1;
    wait_end();
    @(negedge clk);
    chk("rerun_done", {31'd0, done}, 32'd1);
    chk("rerun_write_count", pulses, 32'd7);
    chk("rerun_queue_drained", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
